// File: rtl/enemy_sprite_scheduler.sv
// Shares one sprite-sheet ROM among N enemy slots: hit test, fixed-priority pick, address, and the global animation.
// Optional horizontal mirroring of left-facing enemies is enabled by defining SPR_MIRROR_EN.
module enemy_sprite_scheduler #(
  parameter int N_ENEMIES       = 4,
  parameter int SPR_W           = 40,
  parameter int SPR_H           = 66,
  parameter int N_FRAMES        = 3,
  parameter int FRAME_TICKS     = 8,
  parameter int TRANSPARENT_IDX = 0,
  parameter int ROM_AW          = 13
) (
  input  logic                            vga_clk,
  input  logic                            reset,
  input  logic [9:0]                      DrawX,
  input  logic [9:0]                      DrawY,
  input  logic                            blank,
  input  logic                            frame_start,
  input  logic [N_ENEMIES-1:0]            enemy_active,
  input  logic [10*N_ENEMIES-1:0]         enemy_x,
  input  logic [10*N_ENEMIES-1:0]         enemy_y,
  input  logic [N_ENEMIES-1:0]            enemy_dir,
  output logic [ROM_AW-1:0]               rom_address,
  input  logic [3:0]                      rom_q,
  output logic                            pix_valid,
  output logic [3:0]                      pix_index,
  output logic [$clog2(N_ENEMIES)-1:0]    pix_owner,
  output logic [$clog2(N_FRAMES)-1:0]     anim_frame
);

  localparam int OW  = $clog2(N_ENEMIES);
  localparam int AFW = $clog2(N_FRAMES);
  localparam int TW  = $clog2(FRAME_TICKS);
  localparam logic [ROM_AW-1:0] FRAME_SIZE_A = ROM_AW'(SPR_W * SPR_H);
  localparam logic [ROM_AW-1:0] SPR_W_A      = ROM_AW'(SPR_W);

  logic [TW-1:0] tick;

  // Each slot runs (anim_frame + slot) mod N_FRAMES so neighbours stay out of phase.
  function automatic logic [AFW-1:0] slot_frame(input logic [AFW-1:0] af, input int slot);
    int s;
    s = int'(af) + slot;
    return AFW'(s % N_FRAMES);
  endfunction

  // ---------------- S0: per-slot hit test at 11 bits so edge-clipped sprites never wrap
  logic [10:0]          rel_x [N_ENEMIES];
  logic [10:0]          rel_y [N_ENEMIES];
  logic [N_ENEMIES-1:0] slot_hit;

  always_comb begin
    slot_hit = '0;
    for (int i = 0; i < N_ENEMIES; i++) begin
      rel_x[i]    = {1'b0, DrawX} - {1'b0, enemy_x[10*i +: 10]};
      rel_y[i]    = {1'b0, DrawY} - {1'b0, enemy_y[10*i +: 10]};
      slot_hit[i] = enemy_active[i] && blank
                 && ({1'b0, DrawX} >= {1'b0, enemy_x[10*i +: 10]}) && (rel_x[i] < 11'(SPR_W))
                 && ({1'b0, DrawY} >= {1'b0, enemy_y[10*i +: 10]}) && (rel_y[i] < 11'(SPR_H));
    end
  end

  logic           hit_c;
  logic [OW-1:0]  owner_c;
  logic [10:0]    sel_x;
  logic [10:0]    sel_y;
  logic [10:0]    dx_c;
  logic [AFW-1:0] sel_frame;
  logic           sel_dir;

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    hit_c     = 1'b0;
    owner_c   = '0;
    sel_x     = '0;
    sel_y     = '0;
    sel_frame = '0;
    sel_dir   = 1'b0;
    // Scanning downward lets the lowest-index hitting slot overwrite the others.
    for (int i = N_ENEMIES - 1; i >= 0; i--) begin
      if (slot_hit[i]) begin
        hit_c     = 1'b1;
        owner_c   = OW'(i);
        sel_x     = rel_x[i];
        sel_y     = rel_y[i];
        sel_frame = slot_frame(anim_frame, i);
        sel_dir   = enemy_dir[i];
      end
    end
  end

`ifdef SPR_MIRROR_EN
  assign dx_c = sel_dir ? (11'(SPR_W - 1) - sel_x) : sel_x;
`else
  logic unused_dir;
  assign unused_dir = sel_dir;
  assign dx_c       = sel_x;
`endif

  // ---------------- S1 registers and the pipeline behind them
  logic              hit_s1, hit_d1, hit_d2;
  logic [OW-1:0]     owner_s1, owner_d1, owner_d2;
  logic [AFW-1:0]    frame_s1;
  logic [ROM_AW-1:0] dx_s1, dy_s1;

  // NOTE: sequential state is written with non-blocking assignments so every stage sees pre-edge values.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      hit_s1      <= 1'b0;
      owner_s1    <= '0;
      frame_s1    <= '0;
      dx_s1       <= '0;
      dy_s1       <= '0;
      rom_address <= '0;
      hit_d1      <= 1'b0;
      owner_d1    <= '0;
      hit_d2      <= 1'b0;
      owner_d2    <= '0;
      pix_valid   <= 1'b0;
      pix_index   <= '0;
      pix_owner   <= '0;
    end else begin
      hit_s1   <= hit_c;
      owner_s1 <= owner_c;
      frame_s1 <= sel_frame;
      dx_s1    <= ROM_AW'(dx_c);
      dy_s1    <= ROM_AW'(sel_y);
      // Without a hit the ROM address is left where it was.
      if (hit_s1)
        rom_address <= ROM_AW'(frame_s1) * FRAME_SIZE_A + dy_s1 * SPR_W_A + dx_s1;
      hit_d1   <= hit_s1;
      owner_d1 <= owner_s1;
      hit_d2   <= hit_d1;
      owner_d2 <= owner_d1;
      pix_valid <= hit_d2 && (rom_q != 4'(TRANSPARENT_IDX));
      pix_index <= (hit_d2 && (rom_q != 4'(TRANSPARENT_IDX))) ? rom_q : 4'd0;
      pix_owner <= owner_d2;
    end
  end

  // ---------------- animation sequencer
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      tick       <= '0;
      anim_frame <= '0;
    end else if (frame_start) begin
      if (tick == TW'(FRAME_TICKS - 1)) begin
        tick       <= '0;
        anim_frame <= (anim_frame == AFW'(N_FRAMES - 1)) ? '0 : anim_frame + 1'b1;
      end else begin
        tick <= tick + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_enemy_sprite_scheduler.sv
// Self-checking bench for enemy_sprite_scheduler: directed scenarios plus randomized pixels against a
// slot-scanning reference model; honours SPR_MIRROR_EN the same way the design does.
module tb_enemy_sprite_scheduler;

  logic        vga_clk = 1'b0;
  logic        reset;
  logic [9:0]  DrawX, DrawY;
  logic        blank, frame_start;
  logic [3:0]  enemy_active, enemy_dir;
  logic [39:0] enemy_x, enemy_y;
  logic [12:0] rom_address;
  logic [3:0]  rom_q;
  logic        pix_valid;
  logic [3:0]  pix_index;
  logic [1:0]  pix_owner;
  logic [1:0]  anim_frame;

  logic [3:0]  rom_mem [0:8191];

  int tests = 0;
  int fails = 0;

  // Reference model: animation state, last issued address, and the last four samples (0 = newest).
  int m_tick, m_anim, m_addr;
  bit h_hit  [4];
  int h_addr [4];
  int h_own  [4];

  always #5 vga_clk = ~vga_clk;
  always @(posedge vga_clk) rom_q <= rom_mem[rom_address];

  enemy_sprite_scheduler dut (
    .vga_clk      (vga_clk),
    .reset        (reset),
    .DrawX        (DrawX),
    .DrawY        (DrawY),
    .blank        (blank),
    .frame_start  (frame_start),
    .enemy_active (enemy_active),
    .enemy_x      (enemy_x),
    .enemy_y      (enemy_y),
    .enemy_dir    (enemy_dir),
    .rom_address  (rom_address),
    .rom_q        (rom_q),
    .pix_valid    (pix_valid),
    .pix_index    (pix_index),
    .pix_owner    (pix_owner),
    .anim_frame   (anim_frame)
  );

  function automatic void model_reset();
    m_tick = 0;
    m_anim = 0;
    m_addr = 0;
    for (int k = 0; k < 4; k++) begin
      h_hit[k]  = 1'b0;
      h_addr[k] = 0;
      h_own[k]  = 0;
    end
  endfunction

  task automatic set_slot(input int i, input bit act, input int x, input int y, input bit dir);
    enemy_active[i]     = act;
    enemy_dir[i]        = dir;
    enemy_x[10*i +: 10] = 10'(x);
    enemy_y[10*i +: 10] = 10'(y);
  endtask

  // Drives one pixel, advances the model, and returns 1 time unit after the sampling edge.
  task automatic pixel(input int x, input int y, input bit blk, input bit fs);
    bit hit_m;
    int own_m;
    @(negedge vga_clk);
    DrawX       = 10'(x);
    DrawY       = 10'(y);
    blank       = blk;
    frame_start = fs;
    hit_m = 1'b0;
    own_m = 0;
    for (int i = 0; i < 4; i++) begin
      int ex = int'(enemy_x[10*i +: 10]);
      int ey = int'(enemy_y[10*i +: 10]);
      if (!hit_m && blk && enemy_active[i] && x >= ex && x - ex < 40 && y >= ey && y - ey < 66) begin
        int dx = x - ex;
`ifdef SPR_MIRROR_EN
        if (enemy_dir[i]) dx = 39 - dx;
`endif
        hit_m  = 1'b1;
        own_m  = i;
        m_addr = ((m_anim + i) % 3) * 2640 + (y - ey) * 40 + dx;
      end
    end
    for (int k = 3; k > 0; k--) begin
      h_hit[k]  = h_hit[k-1];
      h_addr[k] = h_addr[k-1];
      h_own[k]  = h_own[k-1];
    end
    h_hit[0]  = hit_m;
    h_addr[0] = m_addr;
    h_own[0]  = own_m;
    if (fs) begin
      if (m_tick == 7) begin
        m_tick = 0;
        m_anim = (m_anim + 1) % 3;
      end else begin
        m_tick++;
      end
    end
    @(posedge vga_clk);
    #1;
  endtask

  task automatic apply_reset();
    reset       = 1'b1;
    blank       = 1'b0;
    frame_start = 1'b0;
    model_reset();
    repeat (2) @(posedge vga_clk);
    @(negedge vga_clk);
    reset = 1'b0;
  endtask

  task automatic flush();
    repeat (4) pixel(0, 0, 1'b0, 1'b0);
  endtask

  task automatic clear_slots();
    for (int i = 0; i < 4; i++) set_slot(i, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge vga_clk);
    #1;
    tests++; if (rom_address !== 13'd0) begin fails++; $display("FAIL reset_addr got %0d want 0", rom_address); end
    tests++; if (pix_valid !== 1'b0)    begin fails++; $display("FAIL reset_valid got %0b want 0", pix_valid); end
    tests++; if (pix_index !== 4'd0)    begin fails++; $display("FAIL reset_index got %0d want 0", pix_index); end
    tests++; if (pix_owner !== 2'd0)    begin fails++; $display("FAIL reset_owner got %0d want 0", pix_owner); end
    tests++; if (anim_frame !== 2'd0)   begin fails++; $display("FAIL reset_anim got %0d want 0", anim_frame); end
    @(negedge vga_clk);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    clear_slots();
    set_slot(0, 1'b1, 100, 200, 1'b0);
    pixel(105, 203, 1'b1, 1'b0);
    pixel(0, 0, 1'b0, 1'b0);
    tests++; if (rom_address !== 13'd125) begin fails++; $display("FAIL basic_addr got %0d want 125", rom_address); end
    pixel(0, 0, 1'b0, 1'b0);
    pixel(0, 0, 1'b0, 1'b0);
    tests++; if (pix_valid !== 1'b1) begin fails++; $display("FAIL basic_valid got %0b want 1", pix_valid); end
    tests++; if (pix_index !== 4'd7) begin fails++; $display("FAIL basic_index got %0d want 7", pix_index); end
    tests++; if (pix_owner !== 2'd0) begin fails++; $display("FAIL basic_owner got %0d want 0", pix_owner); end
  endtask

  task automatic test_anim();
    clear_slots();
    for (int p = 1; p <= 40; p++) begin
      pixel(0, 0, 1'b0, 1'b1);
      tests++; if (anim_frame !== 2'(m_anim)) begin fails++; $display("FAIL anim_step pulse %0d got %0d want %0d", p, anim_frame, m_anim); end
      if (p == 7)  begin tests++; if (anim_frame !== 2'd0) begin fails++; $display("FAIL anim_7 got %0d want 0", anim_frame); end end
      if (p == 8)  begin tests++; if (anim_frame !== 2'd1) begin fails++; $display("FAIL anim_8 got %0d want 1", anim_frame); end end
      if (p == 24) begin tests++; if (anim_frame !== 2'd0) begin fails++; $display("FAIL anim_24 got %0d want 0", anim_frame); end end
      if (p == 40) begin tests++; if (anim_frame !== 2'd2) begin fails++; $display("FAIL anim_40 got %0d want 2", anim_frame); end end
    end
    set_slot(2, 1'b1, 50, 60, 1'b0);
    pixel(50, 60, 1'b1, 1'b0);
    pixel(0, 0, 1'b0, 1'b0);
    tests++; if (rom_address !== 13'd2640) begin fails++; $display("FAIL anim_slot2_base got %0d want 2640", rom_address); end
    flush();
  endtask

  task automatic test_overlap();
    int t_addr;
    clear_slots();
    flush();
    set_slot(1, 1'b1, 300, 100, 1'b0);
    set_slot(3, 1'b1, 300, 100, 1'b0);
    t_addr = ((m_anim + 1) % 3) * 2640 + 5 * 40 + 7;
    rom_mem[t_addr]     = 4'd0;
    rom_mem[t_addr + 1] = 4'd9;
    pixel(307, 105, 1'b1, 1'b0);
    pixel(308, 105, 1'b1, 1'b0);
    tests++; if (rom_address !== 13'(t_addr)) begin fails++; $display("FAIL overlap_addr got %0d want %0d", rom_address, t_addr); end
    pixel(0, 0, 1'b0, 1'b0);
    tests++; if (rom_address !== 13'(t_addr + 1)) begin fails++; $display("FAIL overlap_addr2 got %0d want %0d", rom_address, t_addr + 1); end
    pixel(0, 0, 1'b0, 1'b0);
    tests++; if (pix_valid !== 1'b0) begin fails++; $display("FAIL overlap_transparent got %0b want 0", pix_valid); end
    tests++; if (pix_owner !== 2'd1) begin fails++; $display("FAIL overlap_owner got %0d want 1", pix_owner); end
    pixel(0, 0, 1'b0, 1'b0);
    tests++; if (pix_valid !== 1'b1) begin fails++; $display("FAIL overlap_opaque got %0b want 1", pix_valid); end
    tests++; if (pix_index !== 4'd9) begin fails++; $display("FAIL overlap_index got %0d want 9", pix_index); end
    tests++; if (pix_owner !== 2'd1) begin fails++; $display("FAIL overlap_owner2 got %0d want 1", pix_owner); end
  endtask

  task automatic test_edge();
    int e_addr;
    clear_slots();
    flush();
    set_slot(0, 1'b1, 620, 10, 1'b0);
    e_addr = (m_anim % 3) * 2640 + 10 * 40 + 19;
    rom_mem[e_addr] = 4'hC;
    pixel(639, 20, 1'b1, 1'b0);
    pixel(5, 20, 1'b1, 1'b0);
    tests++; if (rom_address !== 13'(e_addr)) begin fails++; $display("FAIL edge_addr got %0d want %0d", rom_address, e_addr); end
    pixel(639, 20, 1'b0, 1'b0);
    tests++; if (rom_address !== 13'(e_addr)) begin fails++; $display("FAIL edge_hold got %0d want %0d", rom_address, e_addr); end
    pixel(0, 0, 1'b0, 1'b0);
    tests++; if (pix_valid !== 1'b1 || pix_index !== 4'hC) begin fails++; $display("FAIL edge_hit got %0b/%0d want 1/12", pix_valid, pix_index); end
    pixel(0, 0, 1'b0, 1'b0);
    tests++; if (pix_valid !== 1'b0) begin fails++; $display("FAIL edge_nowrap got %0b want 0", pix_valid); end
    pixel(0, 0, 1'b0, 1'b0);
    tests++; if (pix_valid !== 1'b0) begin fails++; $display("FAIL edge_blank got %0b want 0", pix_valid); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      int s, px, py;
      bit blk, fs;
      int exp_v, exp_i;
      if (c % 100 == 0)
        for (int i = 0; i < 4; i++)
          set_slot(i, 1'($urandom_range(0, 1)), int'($urandom_range(0, 1000)),
                   int'($urandom_range(0, 1000)), 1'($urandom_range(0, 1)));
      s   = int'($urandom_range(0, 3));
      px  = (int'(enemy_x[10*s +: 10]) + int'($urandom_range(0, 50)) - 5) & 1023;
      py  = (int'(enemy_y[10*s +: 10]) + int'($urandom_range(0, 76)) - 5) & 1023;
      blk = ($urandom_range(0, 9) != 0);
      fs  = ($urandom_range(0, 19) == 0);
      pixel(px, py, blk, fs);
      exp_v = (h_hit[3] && rom_mem[h_addr[3]] != 4'd0) ? 1 : 0;
      exp_i = exp_v ? int'(rom_mem[h_addr[3]]) : 0;
      tests++; if (rom_address !== 13'(h_addr[1])) begin fails++; $display("FAIL rand_addr cyc %0d got %0d want %0d", c, rom_address, h_addr[1]); end
      tests++; if (pix_valid !== 1'(exp_v)) begin fails++; $display("FAIL rand_valid cyc %0d got %0b want %0d", c, pix_valid, exp_v); end
      tests++; if (pix_index !== 4'(exp_i)) begin fails++; $display("FAIL rand_index cyc %0d got %0d want %0d", c, pix_index, exp_i); end
      tests++; if (anim_frame !== 2'(m_anim)) begin fails++; $display("FAIL rand_anim cyc %0d got %0d want %0d", c, anim_frame, m_anim); end
      if (h_hit[3]) begin
        tests++; if (pix_owner !== 2'(h_own[3])) begin fails++; $display("FAIL rand_owner cyc %0d got %0d want %0d", c, pix_owner, h_own[3]); end
      end
    end
  endtask

  task automatic test_reset_midline();
    clear_slots();
    set_slot(0, 1'b1, 200, 200, 1'b0);
    for (int p = 0; p < 12; p++) pixel(200 + p, 210, 1'b1, 1'b1);
    #2 reset = 1'b1;
    #1;
    tests++; if (rom_address !== 13'd0) begin fails++; $display("FAIL midreset_addr got %0d want 0", rom_address); end
    tests++; if (pix_valid !== 1'b0)    begin fails++; $display("FAIL midreset_valid got %0b want 0", pix_valid); end
    tests++; if (anim_frame !== 2'd0)   begin fails++; $display("FAIL midreset_anim got %0d want 0", anim_frame); end
    frame_start = 1'b1;
    blank       = 1'b1;
    repeat (10) @(posedge vga_clk);
    @(negedge vga_clk);
    frame_start = 1'b0;
    blank       = 1'b0;
    model_reset();
    reset = 1'b0;
    for (int p = 0; p < 3; p++) begin
      pixel(0, 0, 1'b0, 1'b0);
      tests++; if (pix_valid !== 1'b0 || rom_address !== 13'd0) begin fails++; $display("FAIL midreset_flushed step %0d got %0b/%0d want 0/0", p, pix_valid, rom_address); end
    end
    for (int p = 1; p <= 8; p++) pixel(0, 0, 1'b0, 1'b1);
    tests++; if (anim_frame !== 2'd1) begin fails++; $display("FAIL midreset_tick got %0d want 1", anim_frame); end
  endtask

  task automatic test_mirror();
    int want;
`ifdef SPR_MIRROR_EN
    want = 39;
`else
    want = 0;
`endif
    apply_reset();
    clear_slots();
    rom_mem[0] = 4'd0;
    set_slot(0, 1'b1, 0, 0, 1'b1);
    pixel(10, 10, 1'b1, 1'b0);
    pixel(0, 0, 1'b1, 1'b0);
    pixel(0, 0, 1'b0, 1'b0);
    tests++; if (rom_address !== 13'(want)) begin fails++; $display("FAIL mirror_addr got %0d want %0d", rom_address, want); end
  endtask

  initial begin
    reset        = 1'b1;
    DrawX        = '0;
    DrawY        = '0;
    blank        = 1'b0;
    frame_start  = 1'b0;
    enemy_active = '0;
    enemy_dir    = '0;
    enemy_x      = '0;
    enemy_y      = '0;
    for (int i = 0; i < 8192; i++) rom_mem[i] = 4'($urandom_range(0, 15));
    rom_mem[125] = 4'd7;
    model_reset();

    test_reset();
    test_basic();
    test_anim();
    test_overlap();
    test_edge();
    test_random();
    test_reset_midline();
    test_mirror();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
